// File: rtl/otp_pkg.sv
// Shared types and constants for the OTP stream sequencer and its benches.
package otp_pkg;

  localparam int OTP_BYTE_W = 8;
  localparam logic [OTP_BYTE_W-1:0] OTP_DEFAULT_KEY = 8'h27;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    HOLD,
    RELEASE
  } seq_state_t;

endpackage

// File: rtl/otp_seq_watchdog.sv
// Per-byte wait counter: flags when the OTP result may be sampled and when the byte must be abandoned.
module otp_seq_watchdog #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic settled,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign settled = (cnt >= W'(SETTLE_CYCLES));
  assign expired = (cnt == W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/otp_stream_sequencer.sv
// Drives one start/done transaction per byte into the OTP stage and forwards results downstream.
// Define OTP_STREAM_SEQUENCER_CHECKSUM_EN to build the running XOR checksum of delivered bytes.
//
// state   | meaning
// IDLE    | ready for an upstream byte
// START   | first cycle of enc_start
// WAIT    | enc_start held, waiting for enc_done or timeout
// HOLD    | result presented downstream, enc_start low
// RELEASE | one cycle with enc_start low so the OTP lock clears
module otp_stream_sequencer
  import otp_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OTP_BYTE_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OTP_BYTE_W-1:0] enc_input_data,
  output logic                  enc_start,
  input  logic                  enc_done,
  input  logic [OTP_BYTE_W-1:0] enc_output_data,
  output logic [OTP_BYTE_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      byte_count,
  output logic [OTP_BYTE_W-1:0] chk_xor
);

  seq_state_t state, next_state;
  logic hs_in, hs_out, capture, drop;
  logic wd_clr, wd_en, settled, expired;

  otp_seq_watchdog #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .settled(settled),
    .expired(expired)
  );

  always_comb begin
    next_state = state;
    hs_in      = 1'b0;
    hs_out     = 1'b0;
    capture    = 1'b0;
    drop       = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          hs_in      = 1'b1;
          wd_clr     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        wd_en      = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // capture wins over a timeout landing in the same cycle
        if (settled && enc_done) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else if (expired) begin
          drop       = 1'b1;
          next_state = RELEASE;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          hs_out     = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are registered from next_state so they stay low throughout reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      enc_start      <= 1'b0;
      busy           <= 1'b0;
      enc_input_data <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      timeout_err    <= 1'b0;
      byte_count     <= '0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      enc_start <= (next_state == START) || (next_state == WAIT);
      busy      <= (next_state != IDLE);
      if (hs_in) begin
        enc_input_data <= in_data;
      end
      if (capture) begin
        out_data  <= enc_output_data;
        out_valid <= 1'b1;
      end
      if (hs_out) begin
        out_valid  <= 1'b0;
        byte_count <= byte_count + CNT_W'(1);
      end
      if (drop) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef OTP_STREAM_SEQUENCER_CHECKSUM_EN
  logic [OTP_BYTE_W-1:0] chk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_q <= '0;
    end else if (hs_out) begin
      chk_q <= chk_q ^ out_data;
    end
  end

  assign chk_xor = chk_q;
`else
  assign chk_xor = '0;
`endif

endmodule

// File: tb/tb_otp_stream_sequencer.sv
// Directed bench for otp_stream_sequencer with a behavioural XOR-key OTP stage attached.
module tb_otp_stream_sequencer;
  import otp_pkg::*;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       enc_input_data;
  logic             enc_start;
  logic             enc_done;
  logic [7:0]       enc_output_data;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       chk_xor;

  logic stuck = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  otp_stream_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .enc_input_data (enc_input_data),
    .enc_start      (enc_start),
    .enc_done       (enc_done),
    .enc_output_data(enc_output_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .byte_count     (byte_count),
    .chk_xor        (chk_xor)
  );

  // OTP stage stand-in: done follows start unless stuck, result is input XOR key.
  assign enc_done        = enc_start & ~stuck;
  assign enc_output_data = enc_input_data ^ OTP_DEFAULT_KEY;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; stuck = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    in_data = d; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    if (!out_valid) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_timeout: no out_valid for byte %h", d);
    end
    res = out_data;
    tick; tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    tick; tick;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    vectors++; if (enc_start !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_start_busy: got %b%b expected 00", enc_start, busy); end
    vectors++; if (enc_input_data !== 8'h00 || out_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h/%h expected 00/00", enc_input_data, out_data); end
    vectors++; if (out_valid !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_valid_err: got %b%b expected 00", out_valid, timeout_err); end
    vectors++; if (byte_count !== 16'd0 || chk_xor !== 8'h00) begin miscompares++; $display("FAIL rst_count_chk: got %h/%h expected 0/00", byte_count, chk_xor); end
    reset = 1'b0; in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_release_early: got %b expected 0", in_ready); end
    tick;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single;
    int lat;
    do_reset;
    in_data = 8'h41; in_valid = 1'b1;
    tick; lat = 1;
    in_valid = 1'b0;
    vectors++; if (enc_start !== 1'b1 || enc_input_data !== 8'h41) begin miscompares++; $display("FAIL single_start: got %b/%h expected 1/41", enc_start, enc_input_data); end
    vectors++; if (in_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got ready %b busy %b expected 0/1", in_ready, busy); end
    while (!out_valid && lat < 40) begin tick; lat++; end
    vectors++; if (lat !== SETTLE + 2) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d", lat, SETTLE + 2); end
    vectors++; if (out_data !== 8'h66) begin miscompares++; $display("FAIL single_data: got %h expected 66", out_data); end
    vectors++; if (enc_start !== 1'b0) begin miscompares++; $display("FAIL single_hold_start: got %b expected 0", enc_start); end
    tick;
    vectors++; if (out_valid !== 1'b0 || byte_count !== 16'd1) begin miscompares++; $display("FAIL single_release: got valid %b count %0d expected 0/1", out_valid, byte_count); end
    vectors++; if (enc_start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL single_release_ctl: got start %b busy %b ready %b expected 0/1/0", enc_start, busy, in_ready); end
    tick;
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got ready %b busy %b expected 1/0", in_ready, busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes_in [3];
    logic [7:0] exp_out [3];
    logic [7:0] outs [3];
    int idx, nout, rises;
    logic prev_start, acc;
    bytes_in = '{8'h00, 8'hFF, 8'h27};
    exp_out  = '{8'h27, 8'hD8, 8'h00};
    outs     = '{8'h00, 8'h00, 8'h00};
    do_reset;
    idx = 0; nout = 0; rises = 0; prev_start = 1'b0;
    in_data = bytes_in[0]; in_valid = 1'b1;
    for (int c = 0; c < 100 && nout < 3; c++) begin
      acc = in_ready && in_valid;
      tick;
      if (enc_start && !prev_start) rises++;
      prev_start = enc_start;
      if (acc) begin
        idx++;
        if (idx < 3) in_data = bytes_in[idx];
        else in_valid = 1'b0;
      end
      if (out_valid && nout < 3) begin outs[nout] = out_data; nout++; end
    end
    in_valid = 1'b0;
    tick; tick;
    vectors++; if (nout !== 3) begin miscompares++; $display("FAIL b2b_count_out: got %0d expected 3", nout); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (outs[i] !== exp_out[i]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, outs[i], exp_out[i]); end
    end
    vectors++; if (rises !== 3) begin miscompares++; $display("FAIL b2b_start_rises: got %0d expected 3", rises); end
    vectors++; if (byte_count !== 16'd3) begin miscompares++; $display("FAIL b2b_byte_count: got %0d expected 3", byte_count); end
  endtask

  task automatic test_backpressure;
    int n;
    do_reset;
    out_ready = 1'b0;
    in_data = 8'h10; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'h37) begin miscompares++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/37", i, out_valid, out_data); end
      vectors++; if (in_ready !== 1'b0 || byte_count !== 16'd0) begin miscompares++; $display("FAIL bp_stall[%0d]: got ready %b count %0d expected 0/0", i, in_ready, byte_count); end
      tick;
    end
    out_ready = 1'b1;
    tick;
    vectors++; if (out_valid !== 1'b0 || byte_count !== 16'd1) begin miscompares++; $display("FAIL bp_release: got %b/%0d expected 0/1", out_valid, byte_count); end
    tick; tick;
    vectors++; if (byte_count !== 16'd1) begin miscompares++; $display("FAIL bp_single_count: got %0d expected 1", byte_count); end
  endtask

  task automatic test_timeout;
    logic seen;
    logic [7:0] res;
    do_reset;
    stuck = 1'b1;
    in_data = 8'h55; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b expected 0", timeout_err); end
    tick;
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
    vectors++; if (seen !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL to_no_valid: got %b%b expected 00", seen, out_valid); end
    vectors++; if (enc_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_release: got start %b busy %b expected 0/1", enc_start, busy); end
    tick;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL to_idle: got %b expected 1", in_ready); end
    stuck = 1'b0;
    send_byte(8'h01, res);
    vectors++; if (res !== 8'h26) begin miscompares++; $display("FAIL to_next_data: got %h expected 26", res); end
    vectors++; if (timeout_err !== 1'b1 || byte_count !== 16'd1) begin miscompares++; $display("FAIL to_sticky: got %b/%0d expected 1/1", timeout_err, byte_count); end
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] res;
    do_reset;
    send_byte(8'h41, res);
    stuck = 1'b1;
    in_data = 8'h41; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    vectors++; if (enc_start !== 1'b1 || byte_count !== 16'd1) begin miscompares++; $display("FAIL rmw_pre: got start %b count %0d expected 1/1", enc_start, byte_count); end
    reset = 1'b1;
    tick;
    vectors++; if (enc_start !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_start_valid: got %b%b expected 00", enc_start, out_valid); end
    vectors++; if (in_ready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmw_ready_busy: got %b%b expected 00", in_ready, busy); end
    vectors++; if (byte_count !== 16'd0 || enc_input_data !== 8'h00) begin miscompares++; $display("FAIL rmw_count_data: got %0d/%h expected 0/00", byte_count, enc_input_data); end
    reset = 1'b0; stuck = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmw_ready_early: got %b expected 0", in_ready); end
    tick;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rmw_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_checksum;
    logic [7:0] r0, r1, r2;
    logic [7:0] exp_chk;
`ifdef OTP_STREAM_SEQUENCER_CHECKSUM_EN
    exp_chk = 8'h20;
`else
    exp_chk = 8'h00;
`endif
    do_reset;
    send_byte(8'h01, r0);
    send_byte(8'h02, r1);
    send_byte(8'h04, r2);
    vectors++; if (r0 !== 8'h26 || r1 !== 8'h25 || r2 !== 8'h23) begin miscompares++; $display("FAIL chk_results: got %h %h %h expected 26 25 23", r0, r1, r2); end
    vectors++; if (chk_xor !== exp_chk) begin miscompares++; $display("FAIL chk_xor: got %h expected %h", chk_xor, exp_chk); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_reset_mid_wait;
    test_checksum;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
